// File: rtl/final_output_sequencer.sv
// Output-layer sequencer: captures the ten neuron activations, finds the signed argmax,
// then streams the activations plus the class index over AXI4-Stream.
module final_output_sequencer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  input  logic [10*DATA_W-1:0] a_in,
  input  logic [9:0]          done_in,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic [3:0]          class_idx,
  output logic                class_valid,
  output logic                busy,
  output logic                timeout_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_ARGMAX  = 2'd2;
  localparam logic [1:0] S_STREAM  = 2'd3;

  localparam int unsigned     WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [9:0]        mask_q, mask_d;
  logic [DATA_W-1:0] act_q [10];
  logic [DATA_W-1:0] act_d [10];
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [3:0]        k_q, k_d;
  logic [DATA_W-1:0] best_val_q, best_val_d;
  logic [3:0]        best_idx_q, best_idx_d;
  logic [3:0]        beat_q, beat_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic [3:0]        class_idx_q, class_idx_d;
  logic              class_valid_q, class_valid_d;
  logic              timeout_err_q, timeout_err_d;

  logic [9:0]        new_bits;
  logic [9:0]        next_mask;
  logic [DATA_W-1:0] base_val;
  logic [3:0]        base_idx;
  logic [DATA_W-1:0] idx_word;

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    wd_d          = wd_q;
    k_d           = k_q;
    best_val_d    = best_val_q;
    best_idx_d    = best_idx_q;
    beat_d        = beat_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    class_idx_d   = class_idx_q;
    class_valid_d = class_valid_q;
    timeout_err_d = timeout_err_q;
    for (int unsigned i = 0; i < 10; i++) act_d[i] = act_q[i];

    new_bits  = done_in & ~mask_q;
    next_mask = mask_q | new_bits;
    // The first ARGMAX cycle compares against act[0] directly, so no extra init cycle is needed
    base_val  = (k_q == 4'd1) ? act_q[0] : best_val_q;
    base_idx  = (k_q == 4'd1) ? 4'd0 : best_idx_q;
    idx_word  = {{(DATA_W-4){1'b0}}, best_idx_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d        = '0;
          class_valid_d = 1'b0;
          timeout_err_d = 1'b0;
          wd_d          = '0;
          state_d       = S_COLLECT;
        end
      end
      S_COLLECT: begin
        mask_d = next_mask;
        for (int unsigned i = 0; i < 10; i++) begin
          if (new_bits[i]) act_d[i] = a_in[i*DATA_W +: DATA_W];
        end
        wd_d = wd_q + 1'b1;
        // A mask completing on the expiry edge wins over the watchdog
        if (next_mask == 10'h3FF) begin
          k_d     = 4'd1;
          state_d = S_ARGMAX;
        end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_ARGMAX: begin
        best_val_d = base_val;
        best_idx_d = base_idx;
        if ($signed(act_q[k_q]) > $signed(base_val)) begin
          best_val_d = act_q[k_q];
          best_idx_d = k_q;
        end
        k_d = k_q + 4'd1;
        if (k_q == 4'd9) begin
          beat_d   = 4'd0;
          tdata_d  = act_q[0];
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          state_d  = S_STREAM;
        end
      end
      S_STREAM: begin
        if (tvalid_q && m_axis_tready) begin
          if (beat_q == 4'd10) begin
            tvalid_d      = 1'b0;
            tlast_d       = 1'b0;
            class_idx_d   = best_idx_q;
            class_valid_d = 1'b1;
            state_d       = S_IDLE;
          end else begin
            beat_d  = beat_q + 4'd1;
            tlast_d = (beat_q == 4'd9);
            tdata_d = (beat_q == 4'd9) ? idx_word : act_q[beat_q + 4'd1];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      wd_q          <= '0;
      k_q           <= '0;
      best_val_q    <= '0;
      best_idx_q    <= '0;
      beat_q        <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      class_idx_q   <= '0;
      class_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
      for (int unsigned i = 0; i < 10; i++) act_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      wd_q          <= wd_d;
      k_q           <= k_d;
      best_val_q    <= best_val_d;
      best_idx_q    <= best_idx_d;
      beat_q        <= beat_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      class_idx_q   <= class_idx_d;
      class_valid_q <= class_valid_d;
      timeout_err_q <= timeout_err_d;
      for (int unsigned i = 0; i < 10; i++) act_q[i] <= act_d[i];
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign class_idx     = class_idx_q;
  assign class_valid   = class_valid_q;
  assign busy          = (state_q != S_IDLE);
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_final_output_sequencer.sv
// Directed bench for final_output_sequencer: a default-timeout instance for the datapath
// scenarios and a TIMEOUT=16 instance for the watchdog scenario.
module tb_final_output_sequencer;
  localparam int unsigned DW = 32;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic              aresetn, start, start_t, m_axis_tready;
  logic [10*DW-1:0]  a_in;
  logic [9:0]        done_in;

  logic [DW-1:0] m_tdata, t_tdata;
  logic          m_tvalid, t_tvalid, m_tlast, t_tlast;
  logic [3:0]    m_idx, t_idx;
  logic          m_cv, t_cv, m_busy, t_busy, m_terr, t_terr;

  final_output_sequencer #(.DATA_W(DW), .TIMEOUT(1024)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .a_in(a_in), .done_in(done_in),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_tlast), .class_idx(m_idx), .class_valid(m_cv), .busy(m_busy),
    .timeout_err(m_terr));

  final_output_sequencer #(.DATA_W(DW), .TIMEOUT(16)) dut_t (
    .aclk(aclk), .aresetn(aresetn), .start(start_t), .a_in(a_in), .done_in(done_in),
    .m_axis_tdata(t_tdata), .m_axis_tvalid(t_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(t_tlast), .class_idx(t_idx), .class_valid(t_cv), .busy(t_busy),
    .timeout_err(t_terr));

  bit sel;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tlast, s_cv, s_busy;
  logic [3:0]    s_idx;
  assign s_tdata  = sel ? t_tdata  : m_tdata;
  assign s_tvalid = sel ? t_tvalid : m_tvalid;
  assign s_tlast  = sel ? t_tlast  : m_tlast;
  assign s_cv     = sel ? t_cv     : m_cv;
  assign s_busy   = sel ? t_busy   : m_busy;
  assign s_idx    = sel ? t_idx    : m_idx;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_b [11];

  logic [31:0] nom  [10] = '{32'h0000abcd, 32'h1111babe, 32'h2222cafe, 32'h3333dead, 32'h4444efed,
                             32'h5555fade, 32'h6666abcd, 32'h7777babe, 32'h8888cafe, 32'h9999dead};
  logic [31:0] stag [10] = '{32'h00000010, 32'hFFFFFF00, 32'h00000300, 32'h70000000, 32'h00000001,
                             32'h80000000, 32'h00000300, 32'h6FFFFFFF, 32'h00000000, 32'h70000000};
  logic [31:0] tie_a [10] = '{10{32'h00000005}};
  logic [31:0] tie_b [10] = '{32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFFF,
                              32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFF0};

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_acts(input logic [31:0] v [10]);
    for (int i = 0; i < 10; i++) begin
      a_in[i*DW +: DW] = v[i];
      exp_b[i] = v[i];
    end
  endtask

  task automatic pulse(input bit to_t);
    if (to_t) start_t = 1'b1; else start = 1'b1;
    tick;
    start   = 1'b0;
    start_t = 1'b0;
  endtask

  // Walks the selected instance through all 11 beats; every cycle the presented beat is
  // compared, so a stalled beat that changes or a skipped/duplicated beat shows up.
  task automatic stream_check(input bit bp, output int ncyc);
    int beat;
    int stall;
    beat  = 0;
    stall = 0;
    ncyc  = 0;
    while (beat < 11 && ncyc < 300) begin
      if (!bp) m_axis_tready = 1'b1;
      else if (s_tvalid && beat == 10) begin
        m_axis_tready = (stall >= 5);
        stall++;
      end else m_axis_tready = (ncyc % 2 == 1);
      chk("cv_low_in_stream", {31'd0, s_cv}, 32'd0);
      chk("busy_in_stream", {31'd0, s_busy}, 32'd1);
      if (s_tvalid) begin
        chk($sformatf("tdata_beat%0d", beat), s_tdata, exp_b[beat]);
        chk($sformatf("tlast_beat%0d", beat), {31'd0, s_tlast}, (beat == 10) ? 32'd1 : 32'd0);
        if (m_axis_tready) beat++;
      end
      tick;
      ncyc++;
    end
    chk("beats_done", beat, 32'd11);
    chk("tvalid_after", {31'd0, s_tvalid}, 32'd0);
    chk("class_valid", {31'd0, s_cv}, 32'd1);
    chk("class_idx", {28'd0, s_idx}, exp_b[10]);
    chk("busy_after", {31'd0, s_busy}, 32'd0);
    m_axis_tready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int w;
    aresetn = 1'b0; start = 1'b0; start_t = 1'b0; m_axis_tready = 1'b1;
    done_in = '0; a_in = '0; sel = 1'b0;
    repeat (3) tick;
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
    chk("rst_idx", {28'd0, m_idx}, 32'd0);
    chk("rst_cv", {31'd0, m_cv}, 32'd0);
    chk("rst_busy", {31'd0, m_busy}, 32'd0);
    chk("rst_terr", {31'd0, m_terr}, 32'd0);
    aresetn = 1'b1;
    tick;

    // Nominal: first tvalid in cycle 11, beats 11..21, class_valid from 22
    set_acts(nom); exp_b[10] = 32'd7; done_in = 10'h3FF;
    pulse(1'b0);
    chk("nom_busy_c1", {31'd0, m_busy}, 32'd1);
    repeat (9) tick;
    chk("nom_tvalid_c10", {31'd0, m_tvalid}, 32'd0);
    tick;
    chk("nom_tvalid_c11", {31'd0, m_tvalid}, 32'd1);
    stream_check(1'b0, n);
    chk("nom_stream_cycles", n, 32'd11);

    // Staggered done with slices zeroed after capture
    done_in = '0; set_acts(stag); exp_b[10] = 32'd3;
    pulse(1'b0);
    for (int c = 1; c <= 30; c++) begin
      for (int i = 0; i < 10; i++) begin
        if (c == 3 + 2*i) done_in[i] = 1'b1;
        if (c == 4 + 2*i) a_in[i*DW +: DW] = '0;
      end
      chk("stag_tvalid_low", {31'd0, m_tvalid}, 32'd0);
      tick;
    end
    chk("stag_tvalid_c31", {31'd0, m_tvalid}, 32'd1);
    stream_check(1'b0, n);

    // Ties resolve to the lowest index; signed compare with negatives
    done_in = 10'h3FF;
    set_acts(tie_a); exp_b[10] = 32'd0;
    pulse(1'b0);
    stream_check(1'b0, n);
    set_acts(tie_b); exp_b[10] = 32'd4;
    pulse(1'b0);
    stream_check(1'b0, n);

    // Backpressure
    set_acts(nom); exp_b[10] = 32'd7;
    pulse(1'b0);
    stream_check(1'b1, n);

    // Watchdog on the TIMEOUT=16 instance
    sel = 1'b1; done_in = 10'h1FF;
    pulse(1'b1);
    for (int c = 1; c <= 16; c++) begin
      chk("to_busy", {31'd0, t_busy}, 32'd1);
      chk("to_terr_low", {31'd0, t_terr}, 32'd0);
      chk("to_tvalid", {31'd0, t_tvalid}, 32'd0);
      tick;
    end
    chk("to_terr_set", {31'd0, t_terr}, 32'd1);
    chk("to_busy_low", {31'd0, t_busy}, 32'd0);
    repeat (5) tick;
    chk("to_tvalid_never", {31'd0, t_tvalid}, 32'd0);
    chk("to_terr_sticky", {31'd0, t_terr}, 32'd1);
    done_in = 10'h3FF;
    pulse(1'b1);
    chk("to_terr_cleared", {31'd0, t_terr}, 32'd0);
    stream_check(1'b0, n);
    sel = 1'b0;

    // Reset mid-STREAM after three beats
    set_acts(nom); exp_b[10] = 32'd7;
    pulse(1'b0);
    w = 0;
    while (!m_tvalid && w < 50) begin
      tick;
      w++;
    end
    chk("rs_tvalid_up", {31'd0, m_tvalid}, 32'd1);
    repeat (3) tick;
    chk("rs_beat3", m_tdata, exp_b[3]);
    aresetn = 1'b0;
    #1;
    chk("rs_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rs_tdata", m_tdata, 32'd0);
    chk("rs_tlast", {31'd0, m_tlast}, 32'd0);
    chk("rs_idx", {28'd0, m_idx}, 32'd0);
    chk("rs_cv", {31'd0, m_cv}, 32'd0);
    chk("rs_busy", {31'd0, m_busy}, 32'd0);
    tick;
    aresetn = 1'b1;
    tick;
    pulse(1'b0);
    stream_check(1'b0, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/final_output_sequencer.md
# final_output_sequencer

Controller for the output layer of the MNIST network. It captures the ten output-neuron activations as each neuron's done flag asserts, then picks the predicted class with a sequential signed argmax. It streams the ten activations plus the class index over AXI4-Stream and holds the result for the AXI4-Lite register block. It sits between the ten output-neuron datapaths and the final-output register/stream interface.

## Interface
Parameters:
- DATA_W, 32, activation width (signed two's complement)
- TIMEOUT, 1024, max COLLECT cycles before abort; 0 disables the watchdog

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, asynchronous assert, active-low
- start  in  1  begin new inference; sampled only in IDLE
- a_in  in  10*DATA_W  neuron i activation at bits [i*DATA_W +: DATA_W]
- done_in  in  10  level done flag per neuron
- m_axis_tdata  out  DATA_W  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  high on final beat (beat 10)
- class_idx  out  4  argmax result, 0..9
- class_valid  out  1  class_idx valid; held until next start
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky COLLECT abort flag; cleared by start

## Operation
FSM states: IDLE, COLLECT, ARGMAX, STREAM.
- **IDLE:**
  - start=1 clears the captured mask, class_valid, timeout_err and the watchdog counter, then moves to COLLECT.
  - No capture happens in the start cycle.
- **COLLECT:**
  - Each cycle, for every i with done_in[i]=1 and captured[i]=0: latch slice i into act[i] and set captured[i].
  - Only the first-seen value is kept; later changes on a_in are ignored.
  - Move to ARGMAX on the edge where next_mask == 10'h3FF.
  - Watchdog: the counter increments every COLLECT cycle. If it reaches TIMEOUT-1 without a full mask, set timeout_err=1, go to IDLE, and emit no stream.
- **ARGMAX:**
  - Initialise best_val=act[0] and best_idx=0.
  - One compare per cycle for k=1..9, using a signed compare.
  - Replace only on strictly greater, so ties resolve to the lowest index.
  - Exactly 9 cycles, then go to STREAM.
- **STREAM:**
  - 11 beats. Beats 0..9 carry tdata=act[i]. Beat 10 carries tdata={zeros, best_idx}, with tlast=1.
  - A beat completes on tvalid&&tready.
  - On the beat-10 handshake: class_idx=best_idx, class_valid=1, tvalid=0, then go to IDLE.
- start outside IDLE is ignored.
- done_in outside COLLECT is ignored.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, class_idx=0, class_valid=0, busy=0, timeout_err=0. FSM=IDLE, captured mask=0.
- Reset mid-operation clears all state immediately (asynchronously), including dropping tvalid. Everything else recovers on the first edge after deassertion.
- Latency with all done_in high, counting start sampled at edge 0:
  - COLLECT in cycle 1, captures all inputs at edge 1.
  - ARGMAX in cycles 2-10.
  - First tvalid in cycle 11.
  - With tready=1: beats in cycles 11-21, class_valid=1 from cycle 22.
- AXI4-Stream rules:
  - tvalid never drops without a handshake.
  - tdata and tlast stay stable while tvalid=1 and tready=0.
  - No combinational path from tready to tvalid.
- busy=1 from the cycle after start through the beat-10 handshake cycle, and through the timeout cycle.
- Boundary cases:
  - Several done bits rising in the same cycle are all captured that cycle.
  - A mask completing on the same edge as the watchdog expiry counts as success; timeout_err stays 0.

## Test plan
- **Nominal argmax:**
  - Stimulus: act = 0000abcd, 1111babe, 2222cafe, 3333dead, 4444efed, 5555fade, 6666abcd, 7777babe, 8888cafe, 9999dead (8/9 are negative). All done high, tready=1.
  - Response: 11 beats in the order given, beat 10 tdata=7, tlast only on beat 10, first tvalid 11 cycles after start, class_idx=7, class_valid=1.
- **Staggered done:**
  - Stimulus: done[i] rises at cycle 3+2i. a_in slice i changes to 0 one cycle after its done.
  - Response: the streamed values are the pre-change values; ARGMAX starts only after done[9] is captured.
- **Ties and negatives:**
  - Stimulus A: all act=00000005. Response: idx 0.
  - Stimulus B: all act=FFFFFFF0 except act[4]=FFFFFFFF. Response: idx 4.
- **Backpressure:**
  - Stimulus: tready alternates 0/1, plus a 5-cycle stall on beat 10.
  - Response: tdata and tlast stay stable through stalls, no beat is dropped or duplicated, class_valid rises only after the beat-10 handshake.
- **Timeout:**
  - Stimulus: TIMEOUT=16, done[9] held low.
  - Response: timeout_err=1 and busy=0 after 16 COLLECT cycles, tvalid never rises.
  - Follow-up: a new start clears timeout_err, and a full run then completes normally.
- **Reset mid-STREAM:**
  - Stimulus: aresetn asserted after 3 beats.
  - Response: tvalid=0 immediately and all outputs at their reset values; a subsequent start and full run stream all 11 beats from beat 0.
